// File: rtl/sim_run_controller_if.sv
// sim_run_controller_if
//   Groups the run-control handshake between the harness and the run
//   sequencer.
//   Signals:
//     stop_req          harness/DUT -> sequencer, request end of run
//     pause             harness -> sequencer, freeze the run counter
//     CLK_derivedClock  sequencer -> harness, divided clock
//     nRST_derivedReset sequencer -> harness, derived active-low reset
//     started           one-cycle pulse on entry to RUN
//     running           high while the run is in progress
//     done              sticky, run has ended
//     timed_out         sticky, run ended by timeout
//     cycle_count       run cycles counted so far
//   Modports: master (harness side), slave (sequencer side).
interface sim_run_controller_if #(
  parameter int CNT_WIDTH = 32
);
  logic                 stop_req;
  logic                 pause;
  logic                 CLK_derivedClock;
  logic                 nRST_derivedReset;
  logic                 started;
  logic                 running;
  logic                 done;
  logic                 timed_out;
  logic [CNT_WIDTH-1:0] cycle_count;

  modport master (
    output stop_req, pause,
    input  CLK_derivedClock, nRST_derivedReset, started, running,
           done, timed_out, cycle_count
  );

  modport slave (
    input  stop_req, pause,
    output CLK_derivedClock, nRST_derivedReset, started, running,
           done, timed_out, cycle_count
  );
endinterface

// File: rtl/sim_run_controller.sv
// sim_run_controller
//   Simulation run sequencer. After nRST release it holds the derived reset
//   low for RESET_HOLD cycles, waits START_DELAY cycles, pulses 'started',
//   then counts run cycles until stop_req or TIMEOUT_CYCLES, and latches the
//   outcome. A divided clock (CLK / (2*DIV_HALF)) runs in every non-reset
//   state.
//   Ports:
//     CLK   sole clock, rising edge
//     nRST  asynchronous active-low reset
//     bus   sim_run_controller_if.slave (stop_req/pause in, status out)
//   Optional feature: define SIM_RUN_CONTROLLER_FINISH_EN to print run
//   start/end messages and call $finish one cycle after the run ends.
//   Port behaviour is identical with or without the macro.
module sim_run_controller #(
  parameter int RESET_HOLD     = 10,
  parameter int START_DELAY    = 20,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_WIDTH      = 32,
  parameter int DIV_HALF       = 1
) (
  input logic                 CLK,
  input logic                 nRST,
  sim_run_controller_if.slave bus
);

  localparam int PH_MAX = (RESET_HOLD > START_DELAY) ? RESET_HOLD : START_DELAY;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int DIV_W  = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;

  typedef enum logic [1:0] {S_HOLD, S_WAIT, S_RUN, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [PH_W-1:0]      phase_q, phase_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic                 tmo_q, tmo_d;
  logic                 started_q, started_d;
  logic                 running_q, running_d;
  logic                 drst_q, drst_d;
  logic [DIV_W-1:0]     div_q;
  logic                 dclk_q;

  // Next-state and next-output logic.
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned; otherwise synthesis would infer a latch to hold its value.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    done_d    = done_q;
    tmo_d     = tmo_q;
    started_d = 1'b0;
    running_d = running_q;
    drst_d    = drst_q;
    unique case (state_q)
      S_HOLD: begin
        phase_d = phase_q + 1'b1;
        if (phase_q == PH_W'(RESET_HOLD - 1)) begin
          state_d = S_WAIT;
          phase_d = '0;
          drst_d  = 1'b1;
        end
      end
      S_WAIT: begin
        phase_d = phase_q + 1'b1;
        if (phase_q == PH_W'(START_DELAY - 1)) begin
          state_d   = S_RUN;
          phase_d   = '0;
          started_d = 1'b1;
          running_d = 1'b1;
        end
      end
      S_RUN: begin
        // A stop request beats the timeout boundary in the same cycle.
        if (bus.stop_req) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          running_d = 1'b0;
        end else if (!bus.pause) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            tmo_d     = 1'b1;
            running_d = 1'b0;
          end
        end
      end
      S_DONE: ;
      default: state_d = S_HOLD;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= S_HOLD;
      phase_q   <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      tmo_q     <= 1'b0;
      started_q <= 1'b0;
      running_q <= 1'b0;
      drst_q    <= 1'b0;
      div_q     <= '0;
      dclk_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      tmo_q     <= tmo_d;
      started_q <= started_d;
      running_q <= running_d;
      drst_q    <= drst_d;
      // Divided clock runs independently of the FSM; first rise lands
      // DIV_HALF edges after reset release.
      if (div_q == DIV_W'(DIV_HALF - 1)) begin
        div_q  <= '0;
        dclk_q <= ~dclk_q;
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end

  assign bus.CLK_derivedClock  = dclk_q;
  assign bus.nRST_derivedReset = drst_q;
  assign bus.started           = started_q;
  assign bus.running           = running_q;
  assign bus.done              = done_q;
  assign bus.timed_out         = tmo_q;
  assign bus.cycle_count       = cnt_q;

`ifdef SIM_RUN_CONTROLLER_FINISH_EN
  // Simulation-only run reporting; $finish lands one cycle after DONE entry.
  logic finish_q;
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      finish_q <= 1'b0;
    end else begin
      if (state_q != S_RUN && state_d == S_RUN)
        $display("VCSTOP starting");
      if (state_q != S_DONE && state_d == S_DONE) begin
        if (tmo_d) $display("VCSTOP timeout");
        else       $display("VCSTOP end");
      end
      finish_q <= (state_q != S_DONE && state_d == S_DONE);
      if (finish_q) $finish;
    end
  end
`endif

endmodule

// File: tb/tb_sim_run_controller.sv
// tb_sim_run_controller
//   Drives two sequencer instances (default-like timing with a short timeout,
//   and a divide-by-6 derived clock) from shared stimulus. An edge-count based
//   reference model predicts every output each cycle; directed scenarios add
//   hand-computed literal expectations, then randomized stop/pause/reset
//   traffic follows.
module tb_sim_run_controller;

  localparam int A_RH = 10, A_SD = 20, A_TO = 5, A_DH = 1;
  localparam int B_RH = 3,  B_SD = 4,  B_TO = 7, B_DH = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stop_req = 1'b0;
  logic pause = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   edge_n = 0;

  always #5 clk = ~clk;

  sim_run_controller_if #(.CNT_WIDTH(16)) if_a ();
  sim_run_controller_if #(.CNT_WIDTH(8))  if_b ();

  assign if_a.stop_req = stop_req;
  assign if_a.pause    = pause;
  assign if_b.stop_req = stop_req;
  assign if_b.pause    = pause;

  sim_run_controller #(
    .RESET_HOLD(A_RH), .START_DELAY(A_SD), .TIMEOUT_CYCLES(A_TO),
    .CNT_WIDTH(16), .DIV_HALF(A_DH)
  ) dut_a (.CLK(clk), .nRST(rst_n), .bus(if_a.slave));

  sim_run_controller #(
    .RESET_HOLD(B_RH), .START_DELAY(B_SD), .TIMEOUT_CYCLES(B_TO),
    .CNT_WIDTH(8), .DIV_HALF(B_DH)
  ) dut_b (.CLK(clk), .nRST(rst_n), .bus(if_b.slave));

  // Reference model: everything derives from the number of edges since
  // reset release plus the run outcome.
  typedef struct {
    int edges;
    bit done;
    bit tmo;
    int cnt;
  } model_t;

  model_t ma = '{0, 0, 0, 0};
  model_t mb = '{0, 0, 0, 0};

  function automatic model_t step(model_t m, int rh, int sd, int to,
                                  bit stop, bit pse);
    model_t r = m;
    if (m.edges >= rh + sd && !m.done) begin
      if (stop) r.done = 1'b1;
      else if (!pse) begin
        r.cnt = m.cnt + 1;
        if (r.cnt == to) begin
          r.done = 1'b1;
          r.tmo  = 1'b1;
        end
      end
    end
    r.edges = m.edges + 1;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma     <= '{0, 0, 0, 0};
      mb     <= '{0, 0, 0, 0};
      edge_n <= 0;
    end else begin
      ma     <= step(ma, A_RH, A_SD, A_TO, stop_req, pause);
      mb     <= step(mb, B_RH, B_SD, B_TO, stop_req, pause);
      edge_n <= edge_n + 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare(input string tag, input model_t m, input int rh,
                         input int sd, input int dh, input logic dclk,
                         input logic drst, input logic st, input logic run,
                         input logic dn, input logic tmo,
                         input logic [31:0] cnt);
    check({tag, "_dclk"},    64'(dclk), 64'((m.edges / dh) % 2));
    check({tag, "_drst"},    64'(drst), 64'(m.edges >= rh));
    check({tag, "_started"}, 64'(st),   64'(m.edges == rh + sd));
    check({tag, "_running"}, 64'(run),  64'(m.edges >= rh + sd && !m.done));
    check({tag, "_done"},    64'(dn),   64'(m.done));
    check({tag, "_tmo"},     64'(tmo),  64'(m.tmo));
    check({tag, "_cnt"},     64'(cnt),  64'(m.cnt));
  endtask

  task automatic compare_all();
    compare("a", ma, A_RH, A_SD, A_DH, if_a.CLK_derivedClock,
            if_a.nRST_derivedReset, if_a.started, if_a.running, if_a.done,
            if_a.timed_out, 32'(if_a.cycle_count));
    compare("b", mb, B_RH, B_SD, B_DH, if_b.CLK_derivedClock,
            if_b.nRST_derivedReset, if_b.started, if_b.running, if_b.done,
            if_b.timed_out, 32'(if_b.cycle_count));
  endtask

  // Per-cycle comparison, half a period away from the active edge.
  always @(negedge clk) compare_all();

  // Pulse reset mid-cycle; outputs must clear without waiting for an edge.
  task automatic do_reset(input bit hold_stop);
    @(negedge clk);
    #2;
    rst_n    = 1'b0;
    stop_req = hold_stop;
    pause    = 1'b0;
    #1;
    compare_all();
    check("rst_a_outputs",
          64'({if_a.CLK_derivedClock, if_a.nRST_derivedReset, if_a.started,
               if_a.running, if_a.done, if_a.timed_out}), 64'd0);
    check("rst_a_cnt", 64'(if_a.cycle_count), 64'd0);
    check("rst_b_outputs",
          64'({if_b.CLK_derivedClock, if_b.nRST_derivedReset, if_b.done}), 64'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Return at the falling edge that follows rising edge k after release.
  task automatic to_edge(input int k);
    int guard = 0;
    while (edge_n < k && guard < 10000) begin
      @(negedge clk);
      guard++;
    end
    if (edge_n < k) begin
      n_checks++;
      n_fail++;
      $display("FAIL to_edge: reached edge %0d, expected %0d", edge_n, k);
    end
  endtask

  initial begin
    // Bring-up, derived clocks, default timeout.
    do_reset(1'b0);
    to_edge(1);  check("a_dclk_e1", 64'(if_a.CLK_derivedClock), 64'd1);
    to_edge(2);  check("a_dclk_e2", 64'(if_a.CLK_derivedClock), 64'd0);
                 check("b_dclk_e2", 64'(if_b.CLK_derivedClock), 64'd0);
    to_edge(3);  check("b_dclk_e3", 64'(if_b.CLK_derivedClock), 64'd1);
    to_edge(5);  check("b_dclk_e5", 64'(if_b.CLK_derivedClock), 64'd1);
    to_edge(6);  check("b_dclk_e6", 64'(if_b.CLK_derivedClock), 64'd0);
    to_edge(9);  check("a_drst_e9", 64'(if_a.nRST_derivedReset), 64'd0);
    to_edge(10); check("a_drst_e10", 64'(if_a.nRST_derivedReset), 64'd1);
    to_edge(29); check("a_started_e29", 64'(if_a.started), 64'd0);
    to_edge(30); check("a_started_e30", 64'(if_a.started), 64'd1);
                 check("a_running_e30", 64'(if_a.running), 64'd1);
    to_edge(31); check("a_started_e31", 64'(if_a.started), 64'd0);
    to_edge(34); check("a_done_e34", 64'(if_a.done), 64'd0);
    to_edge(35); check("a_timeout_e35",
                       64'({if_a.done, if_a.timed_out, if_a.running}), 64'b110);
                 check("a_cnt_e35", 64'(if_a.cycle_count), 64'd5);
    to_edge(45); check("a_running_e45", 64'(if_a.running), 64'd0);

    // Stop at cycle_count 3, then hold.
    do_reset(1'b0);
    to_edge(33); check("stop_cnt_e33", 64'(if_a.cycle_count), 64'd3);
    stop_req = 1'b1;
    to_edge(34); check("stop_e34", 64'({if_a.done, if_a.timed_out}), 64'b10);
                 check("stop_cnt_e34", 64'(if_a.cycle_count), 64'd3);
    stop_req = 1'b0;
    to_edge(60); check("stop_hold_e60",
                       64'({if_a.done, if_a.timed_out, if_a.cycle_count}),
                       {46'd0, 2'b10, 16'd3});

    // Four pause cycles delay the timeout by four edges.
    do_reset(1'b0);
    to_edge(31); pause = 1'b1;
    to_edge(35); pause = 1'b0;
                 check("pause_cnt_e35", 64'(if_a.cycle_count), 64'd1);
    to_edge(38); check("pause_done_e38", 64'(if_a.done), 64'd0);
    to_edge(39); check("pause_done_e39", 64'({if_a.done, if_a.timed_out}), 64'b11);
                 check("pause_cnt_e39", 64'(if_a.cycle_count), 64'd5);

    // Stop coinciding with the timeout boundary wins.
    do_reset(1'b0);
    to_edge(34); stop_req = 1'b1;
    to_edge(35); check("bound_e35", 64'({if_a.done, if_a.timed_out}), 64'b10);
                 check("bound_cnt_e35", 64'(if_a.cycle_count), 64'd4);
    stop_req = 1'b0;

    // Stop held through HOLD and WAIT only acts at the first RUN edge.
    do_reset(1'b1);
    to_edge(30); check("early_e30", 64'({if_a.done, if_a.running}), 64'b01);
    to_edge(31); check("early_e31",
                       64'({if_a.done, if_a.timed_out, if_a.running}), 64'b100);
                 check("early_cnt_e31", 64'(if_a.cycle_count), 64'd0);
    stop_req = 1'b0;

    // Reset in the middle of RUN, then the full sequence again.
    do_reset(1'b0);
    to_edge(32);
    do_reset(1'b0);
    to_edge(10); check("rerun_drst_e10", 64'(if_a.nRST_derivedReset), 64'd1);
    to_edge(30); check("rerun_started_e30", 64'(if_a.started), 64'd1);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      #2;
      if ((ma.done && mb.done && $urandom_range(0, 3) == 0) ||
          $urandom_range(0, 399) == 0) begin
        do_reset(1'b0);
      end
      stop_req = ($urandom_range(0, 39) == 0);
      pause    = ($urandom_range(0, 3) == 0);
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sim_run_controller.md
# sim_run_controller

Simulation run sequencer that sits beside the top-level DUT wrapper in the verilog simulation harness and replaces hand-timed `#delay` sequencing. Driven by the main `CLK`/`nRST`, it generates the divided `CLK_derivedClock`, sequences `nRST_derivedReset`, and emits a start pulse. It then counts run cycles until the DUT requests a stop or a timeout expires, and reports the outcome.

## Interface
Parameters:
- `RESET_HOLD`, 10: cycles `nRST_derivedReset` is held low after `nRST` release; must be at least 1.
- `START_DELAY`, 20: cycles from derived-reset release to the start pulse; must be at least 1.
- `TIMEOUT_CYCLES`, 1000000: maximum run cycles; must be at least 1 and fit in `CNT_WIDTH`.
- `CNT_WIDTH`, 32: width of the run cycle counter.
- `DIV_HALF`, 1: `CLK` cycles per derived-clock half period; must be at least 1.

Ports:
- `CLK`, in, 1: sole clock, rising-edge.
- `nRST`, in, 1: asynchronous, active-low reset.
- `stop_req`, in, 1: DUT requests end of run; level-sampled.
- `pause`, in, 1: freezes the run counter.
- `CLK_derivedClock`, out, 1: registered divided clock, frequency `CLK`/(2·`DIV_HALF`).
- `nRST_derivedReset`, out, 1: registered derived reset, active-low.
- `started`, out, 1: one-cycle pulse on entry to RUN.
- `running`, out, 1: high while in RUN.
- `done`, out, 1: sticky; run has ended.
- `timed_out`, out, 1: sticky; run ended by timeout.
- `cycle_count`, out, `CNT_WIDTH`: run cycles counted so far.

Reset values: all outputs are 0. `nRST` low forces every output and the FSM to reset state immediately, asynchronously.

## Operation
- FSM states and transitions:
  - HOLD moves to WAIT after `RESET_HOLD` cycles.
  - WAIT moves to RUN after `START_DELAY` cycles.
  - RUN moves to DONE on a stop request or on timeout.
  - DONE is terminal until `nRST`.
- Phase counter:
  - One internal phase counter is reused by HOLD and WAIT.
  - It clears on each state change.
  - Its width is at least clog2(max(`RESET_HOLD`,`START_DELAY`)+1).
- HOLD: `nRST_derivedReset`=0. On the edge where the phase count equals `RESET_HOLD`-1:
  - set `nRST_derivedReset` to 1;
  - go to WAIT.
- WAIT: on the edge where the phase count equals `START_DELAY`-1:
  - go to RUN;
  - set `started`=1 for one cycle and `running`=1.
- RUN: on each edge, in priority order:
  - `stop_req`=1: go to DONE; `done`=1, `running`=0, counter not incremented.
  - `pause`=1: hold the counter.
  - `cycle_count` = `TIMEOUT_CYCLES`-1: increment; go to DONE; `done`=1, `timed_out`=1, `running`=0.
  - Otherwise: increment the counter.
- `stop_req` during HOLD or WAIT is ignored.
- `stop_req` in the same cycle as the timeout boundary wins, so `timed_out` stays 0.
- DONE:
  - `done`, `timed_out` and `cycle_count` hold.
  - `nRST_derivedReset` stays 1.
  - Derived clock keeps toggling.
- Derived clock:
  - Toggle counter runs in every state except reset.
  - Output toggles on every `DIV_HALF`-th `CLK` edge.
  - First rising transition occurs `DIV_HALF` edges after `nRST` release.
- The counter never wraps, because the timeout is reached first.

## Timing
- Edge numbering: edge k is the k-th rising `CLK` edge with `nRST`=1.
- `nRST_derivedReset` rises at edge `RESET_HOLD`.
- `started` is high for the cycle after edge `RESET_HOLD`+`START_DELAY`.
- With no pause and no stop, `done` rises at edge `RESET_HOLD`+`START_DELAY`+`TIMEOUT_CYCLES`, and `cycle_count`=`TIMEOUT_CYCLES`.
- Input-to-output latency for `stop_req`/`pause`: `stop_req` is sampled at an edge and `done` is visible after that same edge.
- Reset mid-run: outputs clear asynchronously. The sequence restarts from HOLD at the first edge after `nRST` release.

## Configuration
- Macro: `SIM_RUN_CONTROLLER_FINISH_EN`.
- Defined:
  - Entering RUN prints `$display("VCSTOP starting")`.
  - Entering DONE prints `$display("VCSTOP end")`, or `"VCSTOP timeout"` if `timed_out`.
  - `$finish` is called one cycle after DONE entry.
- Undefined:
  - No display and no `$finish`.
  - The harness polls `done`.
  - All port behaviour is identical in both cases.

## Test plan
- **Default bring-up.** Defaults, release `nRST` at edge 0. Required:
  - `nRST_derivedReset` high after edge 10;
  - `started` pulses after edge 30;
  - `CLK_derivedClock` period is 2 `CLK` cycles.
- **Timeout.** `TIMEOUT_CYCLES`=5, no stop. Required:
  - `done`=1, `timed_out`=1, `cycle_count`=5 after edge 35;
  - `running` is 0 from then on.
- **Stop request.** Assert `stop_req` when `cycle_count`=3. Required:
  - `done`=1, `timed_out`=0, `cycle_count`=3, held indefinitely.
- **Pause, and stop at the boundary.** `TIMEOUT_CYCLES`=5, `pause` high for 4 cycles mid-run. Required:
  - `done` delayed by exactly 4 cycles.
  - Separately, `stop_req` at `cycle_count`=4 gives `timed_out`=0.
- **Early stop and reset mid-run.**
  - `stop_req` held high through HOLD and WAIT: ignored until RUN, then `done` is set at the first RUN edge.
  - `nRST` pulsed low during RUN: all outputs go to 0 immediately; the full sequence repeats.
- **Derived clock divide.** `DIV_HALF`=3. Required:
  - `CLK_derivedClock` high for 3 cycles, low for 3 cycles;
  - first rise at edge 3.
